// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//   Sequential unsigned multiply-accumulate. It accepts a programmed number of
//   operand pairs over a valid/ready handshake, multiplies each pair in a
//   registered two-stage pipeline, and accumulates the products into a wide
//   sum. The sum is presented over a result valid/ready handshake.
//
// Ports
//   Clock         : single clock, all state on posedge
//   Reset         : synchronous, active-high
//   iStart        : begin a job (honoured only when idle)
//   iLength       : number of terms, latched on an honoured iStart
//   iValid/oReady : operand pair handshake (iA, iB unsigned, SIZE bits each)
//   oResult       : accumulated sum (ACC_WIDTH bits, wraps modulo 2^ACC_WIDTH)
//   oResultValid  : oResult is final; held until iResultReady
//   iResultReady  : consumer takes the result
//   oBusy         : high whenever the block is not idle
module dot_product_accumulator #(
  parameter int SIZE      = 16,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic [CNT_WIDTH-1:0] iLength,
  input  logic                 iValid,
  input  logic [SIZE-1:0]      iA,
  input  logic [SIZE-1:0]      iB,
  output logic                 oReady,
  output logic [ACC_WIDTH-1:0] oResult,
  output logic                 oResultValid,
  input  logic                 iResultReady,
  output logic                 oBusy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  drain_q, drain_d;
  logic [SIZE-1:0]       s1_a_q, s1_a_d;
  logic [SIZE-1:0]       s1_b_q, s1_b_d;
  logic                  s1_v_q, s1_v_d;
  logic [2*SIZE-1:0]     s2_p_q, s2_p_d;
  logic                  s2_v_q, s2_v_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;

  logic                  ready;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  cnt_inc;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s2_p_d  = s2_p_q;
    acc_d   = acc_q;

    ready   = (state_q == S_RUN) && (cnt_q < len_q);
    accept  = iValid && ready;
    cnt_inc = cnt_q + CNT_WIDTH'(1);

    // Stage 1: capture operands on acceptance only.
    s1_v_d = accept;
    if (accept) begin
      s1_a_d = iA;
      s1_b_d = iB;
    end

    // Stage 2: exact full-width product of the stage-1 operands.
    s2_v_d = s1_v_q;
    if (s1_v_q) begin
      s2_p_d = (2*SIZE)'(s1_a_q) * (2*SIZE)'(s1_b_q);
    end

    // Accumulate only real products; bubbles leave the sum untouched.
    if (s2_v_q) begin
      acc_d = acc_q + ACC_WIDTH'(s2_p_q);
    end

    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          len_d   = iLength;
          cnt_d   = '0;
          drain_d = 1'b0;
          acc_d   = '0;
          state_d = (iLength == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        // Two cycles: the last operand reaches the accumulator on the second.
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = S_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE: begin
        if (iResultReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_v_q  <= 1'b0;
      s2_p_q  <= '0;
      s2_v_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_v_q  <= s1_v_d;
      s2_p_q  <= s2_p_d;
      s2_v_q  <= s2_v_d;
      acc_q   <= acc_d;
    end
  end

  assign oReady       = ready;
  assign oResult      = acc_q;
  assign oResultValid = (state_q == S_DONE);
  assign oBusy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_dot_product_accumulator.sv
module tb_dot_product_accumulator;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic [7:0]  iLength;
  logic        iValid;
  logic [15:0] iA;
  logic [15:0] iB;
  logic        iResultReady;

  logic        oReady;
  logic [39:0] oResult;
  logic        oResultValid;
  logic        oBusy;

  logic        r32_ready;
  logic [31:0] r32_result;
  logic        r32_valid;
  logic        r32_busy;

  int n_cmp;
  int n_err;

  dot_product_accumulator #(.SIZE(16), .ACC_WIDTH(40), .CNT_WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iLength(iLength),
    .iValid(iValid), .iA(iA), .iB(iB), .oReady(oReady), .oResult(oResult),
    .oResultValid(oResultValid), .iResultReady(iResultReady), .oBusy(oBusy)
  );

  // Narrow-accumulator instance shares the stimulus; checked for wrap.
  dot_product_accumulator #(.SIZE(16), .ACC_WIDTH(32), .CNT_WIDTH(8)) dut32 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iLength(iLength),
    .iValid(iValid), .iA(iA), .iB(iB), .oReady(r32_ready), .oResult(r32_result),
    .oResultValid(r32_valid), .iResultReady(iResultReady), .oBusy(r32_busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int               len;
    logic [3:0][15:0] a;    // a[0] is the first term
    logic [3:0][15:0] b;
    logic [3:0][1:0]  gap;  // idle cycles before each term
    bit               junk; // hold iValid high with junk while draining
    logic [63:0]      exp;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic start_job(input int len);
    iStart  = 1'b1;
    iLength = 8'(len);
    step();
    iStart = 1'b0;
    chk("busy_after_start", 64'(oBusy), 64'd1);
    chk("ready_after_start", 64'(oReady), 64'(len != 0));
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input int gap, input bit last);
    for (int g = 0; g < gap; g++) begin
      iValid = 1'b0;
      chk("ready_in_gap", 64'(oReady), 64'd1);
      step();
    end
    chk("ready_before_accept", 64'(oReady), 64'd1);
    iValid = 1'b1;
    iA     = a;
    iB     = b;
    step();
    iValid = 1'b0;
    if (last) chk("ready_after_last", 64'(oReady), 64'd0);
  endtask

  task automatic wait_valid(input int exp_lat, input bit junk);
    int lat;
    lat    = 0;
    iValid = junk;
    iA     = 16'd9;
    iB     = 16'd9;
    while (!oResultValid && lat < 10) begin
      step();
      lat++;
    end
    iValid = 1'b0;
    chk("result_latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic ack();
    iResultReady = 1'b1;
    step();
    iResultReady = 1'b0;
    chk("valid_after_ack", 64'(oResultValid), 64'd0);
    chk("busy_after_ack", 64'(oBusy), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    vecs[0].len = 3; vecs[0].a = {16'd0, 16'd65535, 16'd5, 16'd3};
    vecs[0].b = {16'd0, 16'd65535, 16'd6, 16'd4};
    vecs[0].gap = {2'd0, 2'd0, 2'd0, 2'd0}; vecs[0].junk = 1'b0; vecs[0].exp = 64'd4294836267;

    vecs[1].len = 1; vecs[1].a = {16'd0, 16'd0, 16'd0, 16'd65535};
    vecs[1].b = {16'd0, 16'd0, 16'd0, 16'd65535};
    vecs[1].gap = {2'd0, 2'd0, 2'd0, 2'd0}; vecs[1].junk = 1'b1; vecs[1].exp = 64'd4294836225;

    vecs[2].len = 4; vecs[2].a = {16'd4, 16'd3, 16'd2, 16'd1};
    vecs[2].b = {16'd4, 16'd3, 16'd2, 16'd1};
    vecs[2].gap = {2'd3, 2'd0, 2'd1, 2'd0}; vecs[2].junk = 1'b1; vecs[2].exp = 64'd30;

    vecs[3].len = 4; vecs[3].a = {16'd65535, 16'd65535, 16'd65535, 16'd65535};
    vecs[3].b = {16'd65535, 16'd65535, 16'd65535, 16'd65535};
    vecs[3].gap = {2'd0, 2'd0, 2'd0, 2'd0}; vecs[3].junk = 1'b0; vecs[3].exp = 64'd17179344900;

    vecs[4].len = 2; vecs[4].a = {16'd0, 16'd0, 16'd1000, 16'd0};
    vecs[4].b = {16'd0, 16'd0, 16'd1000, 16'd65535};
    vecs[4].gap = {2'd0, 2'd0, 2'd2, 2'd0}; vecs[4].junk = 1'b0; vecs[4].exp = 64'd1000000;

    Reset = 1'b1; iStart = 1'b1; iLength = 8'd3; iValid = 1'b1;
    iA = 16'd1; iB = 16'd1; iResultReady = 1'b0;

    // Reset held 3 cycles with iValid and iStart high.
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_ready", 64'(oReady), 64'd0);
      chk("rst_valid", 64'(oResultValid), 64'd0);
      chk("rst_busy", 64'(oBusy), 64'd0);
      chk("rst_result", 64'(oResult), 64'd0);
    end
    Reset = 1'b0; iStart = 1'b0; iValid = 1'b0;
    step();

    // Table-driven jobs.
    for (int v = 0; v < 5; v++) begin
      start_job(vecs[v].len);
      for (int t = 0; t < vecs[v].len; t++) begin
        push(vecs[v].a[t], vecs[v].b[t], int'(vecs[v].gap[t]), t == vecs[v].len - 1);
      end
      wait_valid(2, vecs[v].junk);
      chk("vec_result", 64'(oResult), vecs[v].exp);
      chk("vec_result32", 64'(r32_result), vecs[v].exp & 64'hFFFF_FFFF);
      ack();
    end

    // Bubbles, result held 5 cycles, iStart ignored in DONE and its handshake cycle.
    start_job(2);
    push(16'd2, 16'd3, 0, 1'b0);
    push(16'd7, 16'd1, 2, 1'b1);
    wait_valid(2, 1'b0);
    iStart  = 1'b1;
    iLength = 8'd0;
    chk("hold_result", 64'(oResult), 64'd13);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_valid", 64'(oResultValid), 64'd1);
      chk("hold_result", 64'(oResult), 64'd13);
    end
    iResultReady = 1'b1;
    step();
    iResultReady = 1'b0;
    chk("idle_after_ack_busy", 64'(oBusy), 64'd0);
    chk("idle_after_ack_valid", 64'(oResultValid), 64'd0);

    // Zero-length job, honoured back-to-back in the cycle after DONE->IDLE.
    step();
    iStart = 1'b0;
    chk("len0_valid", 64'(oResultValid), 64'd1);
    chk("len0_result", 64'(oResult), 64'd0);
    chk("len0_ready", 64'(oReady), 64'd0);
    chk("len0_busy", 64'(oBusy), 64'd1);
    ack();

    // Wrap of the 32-bit accumulator.
    start_job(2);
    push(16'd65535, 16'd65535, 0, 1'b0);
    push(16'd65535, 16'd65535, 0, 1'b1);
    wait_valid(2, 1'b0);
    chk("wide_result", 64'(oResult), 64'd8589672450);
    chk("wrap32_result", 64'(r32_result), 64'd4294705154);
    chk("wrap32_valid", 64'(r32_valid), 64'd1);
    ack();

    // Reset mid-run discards the partial sum.
    start_job(4);
    push(16'd5, 16'd5, 0, 1'b0);
    step();
    step();
    chk("acc_mid_run", 64'(oResult), 64'd25);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midrst_ready", 64'(oReady), 64'd0);
    chk("midrst_valid", 64'(oResultValid), 64'd0);
    chk("midrst_busy", 64'(oBusy), 64'd0);
    chk("midrst_result", 64'(oResult), 64'd0);
    step();
    chk("midrst_still_idle", 64'(oBusy), 64'd0);

    // iStart during RUN neither restarts nor clears the sum.
    start_job(2);
    push(16'd2, 16'd2, 0, 1'b0);
    iStart  = 1'b1;
    iLength = 8'd1;
    push(16'd3, 16'd3, 0, 1'b1);
    iStart = 1'b0;
    wait_valid(2, 1'b0);
    chk("midstart_result", 64'(oResult), 64'd13);
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
